// File: rtl/pulse_to_strobe_pkg.sv
// ============================================================================
// Module   : pulse_to_strobe_pkg
// Brief    : State encodings and default parameters for pulse_to_strobe.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package pulse_to_strobe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_STUCK   = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MIN_WIDTH   = 2;
    localparam int DEF_MAX_WIDTH   = 6;
    localparam int DEF_STUCK_LIMIT = 32;
    localparam int DEF_WCNT_BITS   = 8;
    localparam int DEF_EVT_BITS    = 8;

endpackage

`default_nettype wire

// File: rtl/sync_chain.sv
// ============================================================================
// Module   : sync_chain
// Brief    : Multi-flop synchronizer with configurable depth and reset value.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_chain
    import pulse_to_strobe_pkg::*;
#(
    parameter int   DEPTH     = DEF_SYNC_STAGES,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            chain_q <= {DEPTH{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = chain_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/pulse_to_strobe.sv
// ============================================================================
// Module   : pulse_to_strobe
// Brief    : Converts an asynchronous width-qualified pulse into a one-cycle
//            strobe, flagging bad widths and a stuck-high line.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pulse_to_strobe
    import pulse_to_strobe_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_WIDTH   = DEF_MIN_WIDTH,
    parameter int MAX_WIDTH   = DEF_MAX_WIDTH,
    parameter int STUCK_LIMIT = DEF_STUCK_LIMIT,
    parameter int WCNT_BITS   = DEF_WCNT_BITS,
    parameter int EVT_BITS    = DEF_EVT_BITS
) (
    input  logic                clk_core,
    input  logic                reset,
    input  logic                pulse_in,
    output logic                strobe_out,
    output logic                width_err,
    output logic                stuck_high,
    output logic [EVT_BITS-1:0] event_count,
    output logic                debug_out
);

    localparam logic [WCNT_BITS-1:0] c_min_w   = WCNT_BITS'(MIN_WIDTH);
    localparam logic [WCNT_BITS-1:0] c_max_w   = WCNT_BITS'(MAX_WIDTH);
    localparam logic [WCNT_BITS-1:0] c_stuck_w = WCNT_BITS'(STUCK_LIMIT);

    logic                 s_in;
    logic                 w_in_window;
    state_e               state_q;
    logic [WCNT_BITS-1:0] wcnt_q;
    logic                 strobe_q;
    logic                 err_q;
    logic                 stuck_q;
    logic [EVT_BITS-1:0]  evt_q;

    // Chain resets high so a line already high at reset looks like a pulse in progress.
    sync_chain #(
        .DEPTH     (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i   (clk_core),
        .reset_i (reset),
        .d_i     (pulse_in),
        .q_o     (s_in)
    );

    assign w_in_window = (wcnt_q >= c_min_w) && (wcnt_q <= c_max_w);

    always_ff @(posedge clk_core) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            stuck_q  <= 1'b0;
            evt_q    <= '0;
        end else begin
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!s_in) state_q <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (s_in) begin
                        state_q <= ST_MEASURE;
                        wcnt_q  <= WCNT_BITS'(1);
                    end
                end
                ST_MEASURE: begin
                    if (s_in) begin
                        // Counter saturates at the stuck limit, so it can never wrap.
                        if (wcnt_q == c_stuck_w) begin
                            state_q <= ST_STUCK;
                            stuck_q <= 1'b1;
                        end else begin
                            wcnt_q <= wcnt_q + WCNT_BITS'(1);
                        end
                    end else begin
                        state_q <= ST_ARMED;
                        if (w_in_window) begin
                            strobe_q <= 1'b1;
                            evt_q    <= evt_q + EVT_BITS'(1);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_STUCK: begin
                    if (!s_in) begin
                        state_q <= ST_ARMED;
                        stuck_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign strobe_out  = strobe_q;
    assign width_err   = err_q;
    assign stuck_high  = stuck_q;
    assign event_count = evt_q;
    assign debug_out   = s_in;

endmodule

`default_nettype wire

// File: tb/tb_pulse_to_strobe.sv
// ============================================================================
// Module   : tb_pulse_to_strobe
// Brief    : Directed self-checking bench for pulse_to_strobe.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pulse_to_strobe;

    logic       clk_core = 1'b0;
    logic       reset    = 1'b1;
    logic       pulse_in = 1'b0;
    logic       strobe_out;
    logic       width_err;
    logic       stuck_high;
    logic [7:0] event_count;
    logic       debug_out;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;
    int errs     = 0;
    int both     = 0;

    pulse_to_strobe dut (
        .clk_core    (clk_core),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .strobe_out  (strobe_out),
        .width_err   (width_err),
        .stuck_high  (stuck_high),
        .event_count (event_count),
        .debug_out   (debug_out)
    );

    always #5 clk_core = ~clk_core;

    // Tally strobes and width errors mid-cycle, away from the active edge.
    always @(negedge clk_core) begin
        if (!reset) begin
            strobes <= strobes + int'(strobe_out);
            errs    <= errs + int'(width_err);
            both    <= both + int'(strobe_out & width_err);
        end
    end

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int hi, input int lo);
        pulse_in = 1'b1;
        tick_n(hi);
        pulse_in = 1'b0;
        tick_n(lo);
    endtask

    task automatic test_reset();
        pulse_in = 1'b0;
        reset    = 1'b1;
        tick_n(2);
        n_checks++; if (strobe_out !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", strobe_out); end
        n_checks++; if (width_err !== 1'b0) begin n_fail++; $display("FAIL reset_width_err: got %b expected 0", width_err); end
        n_checks++; if (stuck_high !== 1'b0) begin n_fail++; $display("FAIL reset_stuck: got %b expected 0", stuck_high); end
        n_checks++; if (event_count !== 8'd0) begin n_fail++; $display("FAIL reset_event_count: got %0d expected 0", event_count); end
        n_checks++; if (debug_out !== 1'b1) begin n_fail++; $display("FAIL reset_debug: got %b expected 1", debug_out); end
        reset = 1'b0;
        tick_n(10);
        n_checks++; if (debug_out !== 1'b0) begin n_fail++; $display("FAIL idle_debug: got %b expected 0", debug_out); end
    endtask

    task automatic test_single_pulse();
        pulse_in = 1'b1;
        tick_n(4);
        pulse_in = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++;
            if (strobe_out !== (i == 3)) begin
                n_fail++;
                $display("FAIL single_strobe_cycle%0d: got %b expected %b", i, strobe_out, (i == 3));
            end
            if (i == 3) begin
                n_checks++; if (event_count !== 8'd1) begin n_fail++; $display("FAIL single_event_count: got %0d expected 1", event_count); end
            end
        end
    endtask

    task automatic test_high_at_reset();
        int s0;
        int e0;
        pulse_in = 1'b1;
        reset    = 1'b1;
        tick_n(3);
        reset = 1'b0;
        s0 = strobes;
        e0 = errs;
        tick_n(5);
        n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL high_reset_idle: got state %0d expected 0", dut.state_q); end
        pulse_in = 1'b0;
        tick_n(6);
        n_checks++; if (strobes - s0 !== 0) begin n_fail++; $display("FAIL high_reset_strobes: got %0d expected 0", strobes - s0); end
        n_checks++; if (errs - e0 !== 0) begin n_fail++; $display("FAIL high_reset_errs: got %0d expected 0", errs - e0); end
        n_checks++; if (dut.state_q !== 2'd1) begin n_fail++; $display("FAIL high_reset_armed: got state %0d expected 1", dut.state_q); end
        n_checks++; if (event_count !== 8'd0) begin n_fail++; $display("FAIL high_reset_event_count: got %0d expected 0", event_count); end
    endtask

    task automatic test_width_err();
        int s0;
        int e0;
        s0 = strobes;
        e0 = errs;
        pulse(1, 5);
        pulse(9, 6);
        n_checks++; if (errs - e0 !== 2) begin n_fail++; $display("FAIL width_err_count: got %0d expected 2", errs - e0); end
        n_checks++; if (strobes - s0 !== 0) begin n_fail++; $display("FAIL width_err_strobes: got %0d expected 0", strobes - s0); end
        n_checks++; if (event_count !== 8'd0) begin n_fail++; $display("FAIL width_err_event_count: got %0d expected 0", event_count); end
    endtask

    task automatic test_window_edges();
        int s0;
        int e0;
        s0 = strobes;
        e0 = errs;
        pulse(2, 5);
        n_checks++; if (strobes - s0 !== 1) begin n_fail++; $display("FAIL window_min_strobe: got %0d expected 1", strobes - s0); end
        pulse(6, 5);
        n_checks++; if (strobes - s0 !== 2) begin n_fail++; $display("FAIL window_max_strobe: got %0d expected 2", strobes - s0); end
        pulse(7, 5);
        n_checks++; if (strobes - s0 !== 2) begin n_fail++; $display("FAIL window_over_strobe: got %0d expected 2", strobes - s0); end
        n_checks++; if (errs - e0 !== 1) begin n_fail++; $display("FAIL window_over_err: got %0d expected 1", errs - e0); end
        n_checks++; if (event_count !== 8'd2) begin n_fail++; $display("FAIL window_event_count: got %0d expected 2", event_count); end
    endtask

    task automatic test_stuck();
        int first;
        int e0;
        int s0;
        first = 0;
        e0 = errs;
        s0 = strobes;
        pulse_in = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (stuck_high === 1'b1 && first == 0) first = i;
        end
        n_checks++; if (first !== 35) begin n_fail++; $display("FAIL stuck_rise_cycle: got %0d expected 35", first); end
        pulse_in = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if (stuck_high !== (i < 3)) begin
                n_fail++;
                $display("FAIL stuck_fall_cycle%0d: got %b expected %b", i, stuck_high, (i < 3));
            end
        end
        n_checks++; if (errs - e0 !== 0) begin n_fail++; $display("FAIL stuck_errs: got %0d expected 0", errs - e0); end
        n_checks++; if (strobes - s0 !== 0) begin n_fail++; $display("FAIL stuck_strobes: got %0d expected 0", strobes - s0); end
    endtask

    task automatic test_back_to_back();
        int s0;
        int e0;
        s0 = strobes;
        e0 = errs;
        pulse(4, 1);
        pulse(4, 6);
        n_checks++; if (strobes - s0 !== 2) begin n_fail++; $display("FAIL b2b_strobes: got %0d expected 2", strobes - s0); end
        n_checks++; if (errs - e0 !== 0) begin n_fail++; $display("FAIL b2b_errs: got %0d expected 0", errs - e0); end
        n_checks++; if (event_count !== 8'd4) begin n_fail++; $display("FAIL b2b_event_count: got %0d expected 4", event_count); end
    endtask

    task automatic test_wrap();
        int s0;
        pulse_in = 1'b0;
        reset    = 1'b1;
        tick_n(2);
        reset = 1'b0;
        tick_n(4);
        s0 = strobes;
        for (int i = 0; i < 257; i++) pulse(4, 3);
        tick_n(4);
        n_checks++; if (strobes - s0 !== 257) begin n_fail++; $display("FAIL wrap_strobes: got %0d expected 257", strobes - s0); end
        n_checks++; if (event_count !== 8'd1) begin n_fail++; $display("FAIL wrap_event_count: got %0d expected 1", event_count); end
        n_checks++; if (both !== 0) begin n_fail++; $display("FAIL exclusive_outputs: got %0d expected 0", both); end
    endtask

    task automatic test_reset_mid_pulse();
        int s0;
        int e0;
        pulse_in = 1'b1;
        tick_n(2);
        reset = 1'b1;
        tick();
        n_checks++; if (strobe_out !== 1'b0) begin n_fail++; $display("FAIL mid_reset_strobe: got %b expected 0", strobe_out); end
        n_checks++; if (width_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_width_err: got %b expected 0", width_err); end
        n_checks++; if (stuck_high !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stuck: got %b expected 0", stuck_high); end
        n_checks++; if (event_count !== 8'd0) begin n_fail++; $display("FAIL mid_reset_event_count: got %0d expected 0", event_count); end
        n_checks++; if (debug_out !== 1'b1) begin n_fail++; $display("FAIL mid_reset_debug: got %b expected 1", debug_out); end
        reset = 1'b0;
        s0 = strobes;
        e0 = errs;
        tick();
        pulse_in = 1'b0;
        tick_n(8);
        n_checks++; if (strobes - s0 !== 0) begin n_fail++; $display("FAIL mid_reset_strobes: got %0d expected 0", strobes - s0); end
        n_checks++; if (errs - e0 !== 0) begin n_fail++; $display("FAIL mid_reset_errs: got %0d expected 0", errs - e0); end
        n_checks++; if (dut.state_q !== 2'd1) begin n_fail++; $display("FAIL mid_reset_armed: got state %0d expected 1", dut.state_q); end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_high_at_reset();
        test_width_err();
        test_window_edges();
        test_stuck();
        test_back_to_back();
        test_wrap();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/pulse_to_strobe.md
# pulse_to_strobe

Receiving end of the trigger-pulse link: takes an asynchronous, fixed-width high pulse arriving from another board or clock domain and converts it back into a single-cycle strobe in the `clk_core` domain. The block synchronizes the input, measures the pulse width and accepts only pulses inside a configured window. It flags malformed pulses and a stuck-high line, and counts accepted events for the UART status path.

## Interface
- SYNC_STAGES, 2, synchronizer flop count (≥2)
- MIN_WIDTH, 2, shortest accepted pulse, in synchronized `clk_core` cycles (≥1)
- MAX_WIDTH, 6, longest accepted pulse (MIN_WIDTH ≤ MAX_WIDTH < STUCK_LIMIT)
- STUCK_LIMIT, 32, high-cycle count that declares the line stuck (< 2^WCNT_BITS)
- WCNT_BITS, 8, width counter width
- EVT_BITS, 8, event counter width

Ports:
- clk_core  in  1  sole clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- pulse_in  in  1  asynchronous trigger pulse, idle low
- strobe_out  out  1  one-cycle strobe per accepted pulse
- width_err  out  1  one-cycle flag per rejected pulse (too short or too long)
- stuck_high  out  1  level flag; high while the line is stuck high
- event_count  out  EVT_BITS  count of accepted pulses, wraps
- debug_out  out  1  synchronized input `s_in`

## Operation
- `pulse_in` passes through a SYNC_STAGES flop chain. The last stage is `s_in`. All chain flops reset to 1.
- States:
  - IDLE: after reset; waits for `s_in` = 0, then goes to ARMED. A line that is high at reset therefore never produces a strobe.
  - ARMED: `s_in` = 1 → MEASURE, with `wcnt` = 1.
  - MEASURE: while `s_in` = 1, `wcnt` increments.
    - If `wcnt` = STUCK_LIMIT and `s_in` = 1 → STUCK.
    - If `s_in` = 0 and MIN_WIDTH ≤ `wcnt` ≤ MAX_WIDTH → ARMED, assert `strobe_out`, increment `event_count`.
    - If `s_in` = 0 and `wcnt` is out of window → ARMED, assert `width_err`.
  - STUCK: `stuck_high` = 1. When `s_in` = 0 → ARMED, `stuck_high` = 0. No strobe and no `width_err` are issued for this pulse.
- `wcnt` is unsigned, WCNT_BITS wide and never exceeds STUCK_LIMIT, so it never wraps.
- `event_count` wraps from 2^EVT_BITS−1 to 0 with no flag.
- `strobe_out` and `width_err` are mutually exclusive and are never asserted in consecutive cycles for the same pulse.
- A low gap of one synchronized cycle between pulses is enough: ARMED sees the next high on the following cycle.

## Timing
- Reset values:
  - `strobe_out`, `width_err`, `stuck_high` = 0
  - `event_count` = 0
  - `debug_out` = 1
  - state = IDLE
- Reset takes priority over every other event in the same cycle. Asserting reset mid-pulse discards that pulse.
- All outputs are registered.
- Falling edge of `pulse_in` to `strobe_out`/`width_err`: SYNC_STAGES + 1 cycles.
- `event_count` updates in the same cycle that `strobe_out` is high.
- `stuck_high` rises on the cycle after `wcnt` reaches STUCK_LIMIT. It falls one cycle after `s_in` is seen low.
- Measured width equals the number of `clk_core` cycles `s_in` is high, ±1 from synchronizer sampling. The upstream nominal width must sit mid-window.

## Structure
- Shared package/include holds:
  - state encodings: IDLE = 0, ARMED = 1, MEASURE = 2, STUCK = 3
  - default parameter values
- One sub-module: `sync_chain` (parameterized depth, reset value 1).
- The FSM, width counter and event counter stay in the top module.

## Test plan
- Hold `pulse_in` = 0 for 10 cycles, then drive a 4-cycle high pulse → exactly one `strobe_out`, 3 cycles after the falling edge; `event_count` = 1.
- Hold `pulse_in` = 1 through and after reset, then drive it low → no strobe; state reaches ARMED; `event_count` stays 0.
- Drive a 1-cycle pulse, then a 9-cycle pulse → two `width_err` pulses, no `strobe_out`, `event_count` unchanged.
- Hold `pulse_in` high for 40 cycles → `stuck_high` = 1 after about 34 cycles and clears when the input drops; no `width_err`.
- Drive 257 valid 4-cycle pulses → `event_count` = 1 (wrapped).
- Assert reset during the 3rd cycle of a valid pulse → no strobe; all outputs at reset values the next cycle.
